// File: rtl/vga_timing_checker.sv
// vga_timing_checker
//
// Receive-side monitor for a VGA sync pair running on the pixel clock. It
// recovers the horizontal/vertical position from hsync/vsync, regenerates the
// active-area flag and pixel coordinates, measures line and frame geometry,
// and reports lock and geometry errors.
//
// Ports
//   clk         in   pixel clock, the only clock
//   rst         in   asynchronous active-high reset
//   hsync       in   horizontal sync, active low
//   vsync       in   vertical sync, active low
//   disp_enable out  recovered active-area flag (registered)
//   pixel_x     out  [10:0] column within the active area, 0 outside
//   pixel_y     out  [10:0] row within the active area, 0 outside
//   locked      out  geometry matched for LOCK_FRAMES consecutive frames
//   sync_err    out  one-clock pulse on any geometry mismatch or loss of hsync
//   meas_h_len  out  [11:0] last measured line length in clocks
//   meas_v_len  out  [10:0] last measured frame length in lines
//
// Line order is sync, back porch, display, front porch, with position 0 at
// the sync leading (falling) edge.
module vga_timing_checker #(
  parameter int H_disp      = 1280,
  parameter int H_front     = 48,
  parameter int H_sync      = 112,
  parameter int H_back      = 248,
  parameter int V_disp      = 1024,
  parameter int V_front     = 1,
  parameter int V_sync      = 3,
  parameter int V_back      = 38,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  output logic        disp_enable,
  output logic [10:0] pixel_x,
  output logic [10:0] pixel_y,
  output logic        locked,
  output logic        sync_err,
  output logic [11:0] meas_h_len,
  output logic [10:0] meas_v_len
);

  // ---------------------------------------------------------------------------
  // Mode geometry
  // ---------------------------------------------------------------------------
  localparam int H_TOTAL = H_disp + H_front + H_sync + H_back;
  localparam int V_TOTAL = V_disp + V_front + V_sync + V_back;

  localparam logic [11:0] H_TOTAL_C  = 12'(H_TOTAL);
  localparam logic [11:0] H_SYNC_C   = 12'(H_sync);
  localparam logic [11:0] H_ACT_LO   = 12'(H_sync + H_back);
  localparam logic [11:0] H_ACT_HI   = 12'(H_sync + H_back + H_disp - 1);
  localparam logic [10:0] H_ACT_LO_X = 11'(H_sync + H_back);

  localparam logic [10:0] V_TOTAL_C  = 11'(V_TOTAL);
  localparam logic [10:0] V_SYNC_C   = 11'(V_sync);
  localparam logic [10:0] V_ACT_LO   = 11'(V_sync + V_back);
  localparam logic [10:0] V_ACT_HI   = 11'(V_sync + V_back + V_disp - 1);

  localparam logic [11:0] H_CNT_MAX  = 12'hFFF;
  localparam logic [10:0] V_CNT_MAX  = 11'h7FF;
  localparam logic [3:0]  GOOD_MAX   = 4'hF;
  localparam logic [3:0]  LOCK_C     = 4'(LOCK_FRAMES);

  // ---------------------------------------------------------------------------
  // Input stage: two register stages, reset high so a reset never looks like
  // a sync edge. Edge flags are registered once more so the counter load
  // lands three clocks after the source register changes sync.
  // ---------------------------------------------------------------------------
  logic hs_q1, hs_q2, vs_q1, vs_q2;
  logic h_lead, h_trail, v_lead, v_trail;
  logic vs_low;  // vsync level, time-aligned with the edge flags

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q1   <= 1'b1;
      hs_q2   <= 1'b1;
      vs_q1   <= 1'b1;
      vs_q2   <= 1'b1;
      h_lead  <= 1'b0;
      h_trail <= 1'b0;
      v_lead  <= 1'b0;
      v_trail <= 1'b0;
      vs_low  <= 1'b0;
    end else begin
      hs_q1   <= hsync;
      hs_q2   <= hs_q1;
      vs_q1   <= vsync;
      vs_q2   <= vs_q1;
      h_lead  <= ~hs_q1 & hs_q2;
      h_trail <= hs_q1 & ~hs_q2;
      v_lead  <= ~vs_q1 & vs_q2;
      v_trail <= vs_q1 & ~vs_q2;
      vs_low  <= ~vs_q1;
    end
  end

  // ---------------------------------------------------------------------------
  // Position counters
  // ---------------------------------------------------------------------------
  logic [11:0] h_cnt;
  logic [10:0] v_cnt;
  logic [10:0] v_wid;  // hsync leading edges seen while vsync is low

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
      v_wid <= '0;
    end else begin
      if (h_lead)
        h_cnt <= '0;
      else if (h_cnt != H_CNT_MAX)
        h_cnt <= h_cnt + 12'd1;

      // vsync wins over a coincident hsync edge
      if (v_lead)
        v_cnt <= '0;
      else if (h_lead && v_cnt != V_CNT_MAX)
        v_cnt <= v_cnt + 11'd1;

      // The hsync edge that coincides with the vsync leading edge is the
      // first line of the pulse; one coinciding with the trailing edge is not
      // counted because vs_low has already dropped.
      if (v_lead)
        v_wid <= h_lead ? 11'd1 : 11'd0;
      else if (vs_low && h_lead && v_wid != V_CNT_MAX)
        v_wid <= v_wid + 11'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Captured geometry (values as they are latched on their edges)
  // ---------------------------------------------------------------------------
  logic [11:0] h_len_now;  // line length ending at this hsync leading edge
  logic [11:0] h_wid_now;  // hsync pulse width ending at this trailing edge
  logic [10:0] v_len_now;  // frame length ending at this vsync leading edge

  always_comb begin
    h_len_now = (h_cnt == H_CNT_MAX) ? H_CNT_MAX : h_cnt + 12'd1;
    h_wid_now = h_len_now;
    v_len_now = v_cnt;
    if (h_lead)
      v_len_now = (v_cnt == V_CNT_MAX) ? V_CNT_MAX : v_cnt + 11'd1;
  end

  // ---------------------------------------------------------------------------
  // Mismatch detection
  // ---------------------------------------------------------------------------
  logic frame_valid;  // first vsync leading edge seen since reset
  logic frame_bad;    // some check failed inside the current frame
  logic [3:0] good_cnt;

  logic h_len_bad, h_wid_bad, v_len_bad, v_wid_bad, los_hit;
  logic any_err, frame_good;

  always_comb begin
    h_len_bad  = frame_valid & h_lead  & (h_len_now != H_TOTAL_C);
    h_wid_bad  = frame_valid & h_trail & (h_wid_now != H_SYNC_C);
    v_len_bad  = frame_valid & v_lead  & (v_len_now != V_TOTAL_C);
    v_wid_bad  = frame_valid & v_trail & (v_wid != V_SYNC_C);
    // h_cnt is about to reach saturation; fires once because the counter
    // then sits at 4095 and never passes 4094 again until hsync returns.
    los_hit    = ~h_lead & (h_cnt == H_CNT_MAX - 12'd1);
    any_err    = h_len_bad | h_wid_bad | v_len_bad | v_wid_bad | los_hit;
    // A frame ends at a vsync leading edge; any error on that same edge
    // (its last line or its length) still belongs to the ending frame.
    frame_good = frame_valid & v_lead & ~frame_bad & ~any_err;
  end

  // ---------------------------------------------------------------------------
  // Measurement, lock and error reporting
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meas_h_len  <= '0;
      meas_v_len  <= '0;
      frame_valid <= 1'b0;
      frame_bad   <= 1'b0;
      good_cnt    <= '0;
      sync_err    <= 1'b0;
      locked      <= 1'b0;
    end else begin
      if (h_lead)
        meas_h_len <= h_len_now;
      if (v_lead)
        meas_v_len <= v_len_now;

      if (v_lead)
        frame_valid <= 1'b1;

      if (v_lead)
        frame_bad <= 1'b0;
      else if (any_err)
        frame_bad <= 1'b1;

      if (any_err)
        good_cnt <= '0;
      else if (frame_good && good_cnt != GOOD_MAX)
        good_cnt <= good_cnt + 4'd1;

      sync_err <= any_err;

      // Lock follows the good-frame count one clock after it updates, but
      // drops on the same clock as the error.
      if (any_err)
        locked <= 1'b0;
      else
        locked <= (good_cnt >= LOCK_C);
    end
  end

  // ---------------------------------------------------------------------------
  // Active area and pixel coordinates
  // ---------------------------------------------------------------------------
  logic in_h, in_v;

  always_comb begin
    in_h = (h_cnt >= H_ACT_LO) && (h_cnt <= H_ACT_HI);
    in_v = (v_cnt >= V_ACT_LO) && (v_cnt <= V_ACT_HI);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_enable <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
    end else begin
      disp_enable <= in_h & in_v;
      if (in_h && in_v) begin
        // Offsets fit in 11 bits inside the active window.
        pixel_x <= h_cnt[10:0] - H_ACT_LO_X;
        pixel_y <= v_cnt - V_ACT_LO;
      end else begin
        pixel_x <= '0;
        pixel_y <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_checker.sv
// tb_vga_timing_checker
//
// Bench for vga_timing_checker using a reduced video mode so whole frames
// fit in a short run. A sync generator in the bench drives hsync/vsync on the
// falling clock edge and keeps its own model of the position (clocks since
// the last hsync fall, lines since the last vsync fall). For every driven
// cycle the expected {disp_enable, pixel_x, pixel_y} is queued; a monitor pops
// and compares the entry whose result the DUT presents three rising edges
// later. Lock, error and measurement behaviour is checked at frame
// boundaries from values the monitor records.
module tb_vga_timing_checker;

  // Reduced mode: H total 17 clocks, V total 9 lines.
  localparam int HD = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 4;
  localparam int VD = 4;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int LF = 2;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int HA = HS + HB;
  localparam int VA = VS + VB;
  localparam int W  = 24;  // {check, de, x[10:0], y[10:0]}

  logic        clk;
  logic        rst;
  logic        hsync;
  logic        vsync;
  logic        disp_enable;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic        locked;
  logic        sync_err;
  logic [11:0] meas_h_len;
  logic [10:0] meas_v_len;

  vga_timing_checker #(
    .H_disp(HD), .H_front(HF), .H_sync(HS), .H_back(HB),
    .V_disp(VD), .V_front(VF), .V_sync(VS), .V_back(VB),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hsync(hsync),
    .vsync(vsync),
    .disp_enable(disp_enable),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .locked(locked),
    .sync_err(sync_err),
    .meas_h_len(meas_h_len),
    .meas_v_len(meas_v_len)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  // generator model
  int   hp = 0;
  int   vp = 0;
  logic prev_hs = 1'b1;
  logic prev_vs = 1'b1;
  logic synced = 1'b0;
  int   cur_line = 0;

  // monitor observations
  int err_cnt = 0;
  int err_h_snap = 0;
  int err_line = -1;
  int de_cnt = 0;
  bit first_seen = 1'b0;
  int first_px = -1;
  int first_py = -1;
  int last_px = -1;
  int last_py = -1;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic drive(input logic hs, input logic vs);
    logic        de;
    logic [10:0] ex;
    logic [10:0] ey;
    @(negedge clk);
    hsync = hs;
    vsync = vs;
    if (prev_hs && !hs) hp = 0;
    else if (hp < 4095) hp++;
    if (prev_vs && !vs) begin
      vp = 0;
      if (!rst) synced = 1'b1;
    end else if (prev_hs && !hs && vp < 2047) begin
      vp++;
    end
    prev_hs = hs;
    prev_vs = vs;
    de = (hp >= HA) && (hp <= HA + HD - 1) && (vp >= VA) && (vp <= VA + VD - 1);
    ex = de ? 11'(hp - HA) : 11'd0;
    ey = de ? 11'(vp - VA) : 11'd0;
    exp_q.push_back({synced, de, ex, ey});
  endtask

  task automatic line(input int l, input int len, input int vs_lines);
    cur_line = l;
    for (int p = 0; p < len; p++)
      drive((p < HS) ? 1'b0 : 1'b1, (l < vs_lines) ? 1'b0 : 1'b1);
  endtask

  task automatic frame(input int long_line, input int vs_lines);
    for (int l = 0; l < VT; l++)
      line(l, (l == long_line) ? HT + 1 : HT, vs_lines);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: result for the cycle driven before rising edge c is visible
  // after rising edge c+3, so the oldest of four queued entries is due.
  // ---------------------------------------------------------------------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (sync_err) begin
        err_cnt++;
        err_h_snap = int'(meas_h_len);
        err_line = cur_line;
      end
      if (disp_enable) begin
        de_cnt++;
        if (!first_seen) begin
          first_seen = 1'b1;
          first_px = int'(pixel_x);
          first_py = int'(pixel_y);
        end
        last_px = int'(pixel_x);
        last_py = int'(pixel_y);
      end
      if (exp_q.size() >= 4) begin
        e = exp_q.pop_front();
        if (e[23]) begin
          checks++;
          if ({disp_enable, pixel_x, pixel_y} != e[22:0]) begin
            errors++;
            $display("FAIL pixel @%0t: got de=%0d x=%0d y=%0d, expected de=%0d x=%0d y=%0d",
                     $time, disp_enable, pixel_x, pixel_y, e[22], e[21:11], e[10:0]);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected end of sequence");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int e0;
    rst = 1'b1;
    hsync = 1'b1;
    vsync = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_disp_enable", int'(disp_enable), 0);
    check("rst_pixel_x", int'(pixel_x), 0);
    check("rst_pixel_y", int'(pixel_y), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_meas_h_len", int'(meas_h_len), 0);
    check("rst_meas_v_len", int'(meas_v_len), 0);
    rst = 1'b0;

    repeat (5) drive(1'b1, 1'b1);

    // Clean frames: first vsync starts checking, lock after two good frames
    frame(-1, VS);
    check("f1_meas_h_len", int'(meas_h_len), HT);
    frame(-1, VS);
    check("f2_meas_v_len", int'(meas_v_len), VT);
    check("f2_not_locked", int'(locked), 0);
    frame(-1, VS);
    check("f3_locked", int'(locked), 1);

    de_cnt = 0;
    first_seen = 1'b0;
    frame(-1, VS);
    check("f4_de_count", de_cnt, HD * VD);
    check("f4_first_x", first_px, 0);
    check("f4_first_y", first_py, 0);
    check("f4_last_x", last_px, HD - 1);
    check("f4_last_y", last_py, VD - 1);
    check("f4_meas_h_len", int'(meas_h_len), HT);
    check("f4_meas_v_len", int'(meas_v_len), VT);
    check("clean_no_sync_err", err_cnt, 0);
    check("f4_locked", int'(locked), 1);

    // One long line while locked
    e0 = err_cnt;
    frame(4, VS);
    check("long_line_err_pulses", err_cnt - e0, 1);
    check("long_line_meas_h_len", err_h_snap, HT + 1);
    check("long_line_unlocked", int'(locked), 0);
    frame(-1, VS);
    frame(-1, VS);
    check("relock_not_yet", int'(locked), 0);
    frame(-1, VS);
    check("relock", int'(locked), 1);

    // Loss of hsync
    e0 = err_cnt;
    repeat (5000) drive(1'b1, 1'b1);
    check("los_err_pulses", err_cnt - e0, 1);
    check("los_unlocked", int'(locked), 0);
    frame(-1, VS);
    frame(-1, VS);
    frame(-1, VS);
    check("relock_after_los", int'(locked), 1);

    // Reset in the middle of a frame while locked
    for (int l = 0; l < 4; l++) line(l, HT, VS);
    #2;
    rst = 1'b1;
    synced = 1'b0;
    exp_q.delete();
    #1;
    check("arst_disp_enable", int'(disp_enable), 0);
    check("arst_pixel_x", int'(pixel_x), 0);
    check("arst_pixel_y", int'(pixel_y), 0);
    check("arst_locked", int'(locked), 0);
    check("arst_sync_err", int'(sync_err), 0);
    check("arst_meas_h_len", int'(meas_h_len), 0);
    check("arst_meas_v_len", int'(meas_v_len), 0);
    repeat (3) drive(1'b1, 1'b1);
    rst = 1'b0;
    e0 = err_cnt;
    for (int l = 4; l < VT; l++) line(l, HT, VS);
    frame(-1, VS);
    frame(-1, VS);
    check("post_rst_no_sync_err", err_cnt - e0, 0);
    check("post_rst_not_locked", int'(locked), 0);
    frame(-1, VS);
    check("post_rst_locked", int'(locked), 1);

    // Four-line vsync pulse
    e0 = err_cnt;
    frame(-1, 4);
    check("vwidth_err_pulses", err_cnt - e0, 1);
    check("vwidth_err_line", err_line, 4);
    check("vwidth_unlocked", int'(locked), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_checker.md
# vga_timing_checker

Receive-side counterpart of the VGA timing generator: it watches an hsync/vsync pair running on the pixel clock, recovers the horizontal and vertical position, and regenerates `disp_enable` plus pixel coordinates. It also measures line/frame geometry against the expected mode and reports lock and errors. It sits on the loopback/monitor path, fed either by the generator's sync outputs or by the sync pins of an external source on the same clock.

## Interface
- `H_disp`, 1280, active pixels per line
- `H_front`, 48, horizontal front porch (clocks)
- `H_sync`, 112, hsync pulse width (clocks)
- `H_back`, 248, horizontal back porch (clocks)
- `V_disp`, 1024, active lines per frame
- `V_front`, 1, vertical front porch (lines)
- `V_sync`, 3, vsync pulse width (lines)
- `V_back`, 38, vertical back porch (lines)
- `LOCK_FRAMES`, 2, consecutive good frames required for lock (1..15)

- `clk`  in  1  pixel clock; the block's only clock
- `rst`  in  1  asynchronous, active-high reset
- `hsync`  in  1  horizontal sync, active low
- `vsync`  in  1  vertical sync, active low
- `disp_enable`  out  1  recovered active-area flag
- `pixel_x`  out  11  column within the active area, 0 outside it
- `pixel_y`  out  11  row within the active area, 0 outside it
- `locked`  out  1  geometry matched for `LOCK_FRAMES` consecutive frames
- `sync_err`  out  1  one-clock pulse on any geometry mismatch
- `meas_h_len`  out  12  last measured line length (clocks)
- `meas_v_len`  out  11  last measured frame length (lines)

## Operation
- Derived constants: H_total = sum of the H parameters (1688); V_total = sum of the V parameters (1066). Line order is sync, back porch, display, front porch, starting at the sync leading edge.
- Input stage: `hsync` and `vsync` are registered twice (q1, q2). A leading edge is q1=0 and q2=1. A trailing edge is q1=1 and q2=0.
- `h_cnt` is 12 bits. It loads 0 on an hsync leading edge, otherwise increments, and saturates at 4095.
- On an hsync leading edge, `meas_h_len` <= h_cnt+1.
- On an hsync trailing edge, the h pulse width is captured as h_cnt+1.
- `v_cnt` is 11 bits. It loads 0 on a vsync leading edge. Otherwise it increments on each hsync leading edge and saturates at 2047. Vsync has priority when both edges occur together.
- On a vsync leading edge, `meas_v_len` <= v_cnt + (1 if an hsync leading edge coincides, else 0).
- The v pulse width is the number of hsync leading edges seen while vsync is low.
- Active area: h_cnt in [H_sync+H_back, H_sync+H_back+H_disp-1] = [360, 1639], and v_cnt in [41, 1064].
- `pixel_x` = h_cnt-360 and `pixel_y` = v_cnt-41 inside the active area, 0 outside. All three outputs are registered.
- Checking uses a `frame_valid` flag. It is set by the first vsync leading edge after reset; no comparison is made before it.
- After `frame_valid`, each captured value is compared with its expected value. Any mismatch produces:
  - `sync_err` = 1 for one clock,
  - `locked` = 0,
  - good-frame counter cleared.
- A frame is good when every line's h length and h width matched and the frame's v length and v width matched. Each good frame increments the good-frame counter, which saturates.
- `locked` is set when the counter reaches `LOCK_FRAMES`.
- Loss of signal: if h_cnt reaches 4095, `sync_err` pulses once (not repeated while saturated), `locked` = 0, and the counter clears.

## Timing
- Reset values: all outputs 0, counters 0, `frame_valid` 0, and both input-register stages set to 1 (inactive) so no false edge is seen.
- Reset asserted mid-frame forces this state immediately. After release, lock needs a fresh first vsync edge plus `LOCK_FRAMES` good frames.
- Latency: an hsync falling at input clock edge k gives h_cnt = 0 at edge k+3. `disp_enable`, `pixel_x` and `pixel_y` appear one clock later, a fixed 4 clocks from input to output.
- `meas_*` and `sync_err` update on the same clock as the h_cnt/v_cnt load that triggers them. `locked` updates one clock after the frame-end capture.
- A vsync edge not aligned to an hsync edge is legal. v_cnt still reloads, and the mismatch, if any, is reported through `meas_v_len`.

## Test plan
- Drive the generator on default parameters for 4 frames, then compare every output against the generator's own timing:
  - `meas_h_len` = 1688 and `meas_v_len` = 1066,
  - `locked` rises at the end of frame 3 (the first vsync edge only starts checking, then 2 good frames),
  - `sync_err` never pulses.
- Active-area tracking:
  - first `disp_enable` = 1 occurs 4 clocks after h_cnt would be 360 on line 41, with `pixel_x` = 0 and `pixel_y` = 0,
  - last active pixel has `pixel_x` = 1279 and `pixel_y` = 1023,
  - `disp_enable` is high for 1280 × 1024 clocks per frame.
- Lengthen one line to 1689 clocks while locked: one `sync_err` pulse, `meas_h_len` = 1689, `locked` = 0, relock after 2 further good frames.
- Hold `hsync` high for 5000 clocks: h_cnt saturates at 4095, exactly one `sync_err` pulse, `locked` = 0.
- Assert `rst` mid-frame while locked: all outputs go to 0 asynchronously, and no `sync_err` occurs on the first edges after release.
- Drive vsync low with a 4-line pulse: `sync_err` pulses at the trailing edge and `locked` deasserts.
